// File: rtl/pixel_delay_line.sv
// pixel_delay_line: runtime-programmable circular-buffer delay for a pixel word and its timing bits,
// with priming/valid tracking and sticky range checking of the requested delay.
module pixel_delay_line #(
    parameter int DATA_W    = 24,
    parameter int CTRL_W    = 3,
    parameter int MAX_DEPTH = 64,
    parameter int SEL_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic              pixelclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [SEL_W-1:0]  delay_sel,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_valid,
    output logic              cfg_err
);
    localparam int PW = $clog2(MAX_DEPTH);
    localparam int W  = DATA_W + CTRL_W;
    localparam logic [SEL_W-1:0] MAXD  = SEL_W'(MAX_DEPTH);
    localparam logic [PW-1:0]    LAST  = PW'(MAX_DEPTH - 1);
    localparam logic [SEL_W:0]   DEPTH = (SEL_W + 1)'(MAX_DEPTH);
    localparam logic [SEL_W:0]   DEPTH_P1 = (SEL_W + 1)'(MAX_DEPTH + 1);

    logic [W-1:0]     mem [MAX_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_idx;
    logic [SEL_W-1:0] delay_q, deff, fill_q, fill_d;
    logic [SEL_W:0]   rd_sum;
    logic [W-1:0]     rd_word, out_q, out_d;
    logic             init_q, restart, oor, valid_q, valid_d, cfg_err_q;

    always_comb begin
        oor      = (delay_sel == '0) || (delay_sel > MAXD);
        deff     = (delay_sel == '0) ? SEL_W'(1) : ((delay_sel > MAXD) ? MAXD : delay_sel);
        restart  = init_q && (deff != delay_q);
        wr_ptr_d = en ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        // Entry written Deff-1 enabled edges ago; Deff=1 bypasses the buffer.
        rd_sum   = (SEL_W + 1)'(wr_ptr_q) + DEPTH_P1 - {1'b0, deff};
        rd_idx   = PW'((rd_sum >= DEPTH) ? rd_sum - DEPTH : rd_sum);
        rd_word  = (deff == SEL_W'(1)) ? {i_ctrl, i_data} : mem[rd_idx];
        fill_d   = restart ? '0 : ((en && fill_q != deff) ? fill_q + 1'b1 : fill_q);
        valid_d  = restart ? 1'b0 : (en ? (fill_d == deff) : valid_q);
        out_d    = restart ? '0 : (en ? (valid_d ? rd_word : '0) : out_q);
    end

    always_ff @(posedge pixelclk)
        if (en) mem[wr_ptr_q] <= {i_ctrl, i_data};

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            delay_q   <= '0;
            init_q    <= 1'b0;
            valid_q   <= 1'b0;
            out_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            delay_q   <= deff;
            init_q    <= 1'b1;
            valid_q   <= valid_d;
            out_q     <= out_d;
            cfg_err_q <= cfg_err_q | oor;
        end
    end

    assign o_data  = out_q[DATA_W-1:0];
    assign o_ctrl  = out_q[W-1:DATA_W];
    assign o_valid = valid_q;
    assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_pixel_delay_line.sv
// tb_pixel_delay_line: directed self-checking bench for pixel_delay_line.
module tb_pixel_delay_line;
    logic        pixelclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [6:0]  delay_sel = '0;
    logic [23:0] i_data = '0;
    logic [2:0]  i_ctrl = '0;
    logic [23:0] o_data;
    logic [2:0]  o_ctrl;
    logic        o_valid;
    logic        cfg_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [27:0] got, exp;
    logic [28:0] got_e, exp_e;

    always #5 pixelclk = ~pixelclk;

    pixel_delay_line dut (
        .pixelclk(pixelclk), .rst_n(rst_n), .en(en), .delay_sel(delay_sel),
        .i_data(i_data), .i_ctrl(i_ctrl), .o_data(o_data), .o_ctrl(o_ctrl),
        .o_valid(o_valid), .cfg_err(cfg_err)
    );

    task automatic tick;
        @(posedge pixelclk);
        #1;
    endtask

    task automatic do_reset(input logic [6:0] d);
        rst_n = 1'b0;
        en = 1'b0;
        delay_sel = d;
        i_data = '0;
        i_ctrl = '0;
        tick();
        tick();
        rst_n = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        delay_sel = 7'd56;
        tick();
        got_e = {cfg_err, o_valid, o_ctrl, o_data};
        n_cmp++;
        if (got_e !== '0) begin
            n_bad++;
            $display("FAIL reset_state got %h exp %h", got_e, 29'h0);
        end
        rst_n = 1'b1;
        en = 1'b1;
        i_data = 24'h55AA55;
        i_ctrl = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            got_e = {cfg_err, o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got_e !== '0) begin
                n_bad++;
                $display("FAIL reset_release i=%0d got %h exp %h", i, got_e, 29'h0);
            end
        end
    endtask

    task automatic test_baseline;
        do_reset(7'd56);
        for (int n = 0; n < 80; n++) begin
            i_data = 24'(n + 1);
            i_ctrl = 3'(n);
            tick();
            exp = (n < 55) ? '0 : {1'b1, 3'(n - 55), 24'(n - 54)};
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL baseline n=%0d got %h exp %h", n, got, exp);
            end
        end
    endtask

    task automatic test_enable_gaps;
        int k;
        do_reset(7'd4);
        k = 0;
        exp = '0;
        for (int i = 0; i < 40; i++) begin
            en = (i % 2 == 0);
            if (en) k++;
            i_data = en ? 24'(k) : 24'hABCDEF;
            tick();
            if (en) exp = (k >= 4) ? {1'b1, 3'b0, 24'(k - 3)} : '0;
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL enable_gaps i=%0d k=%0d got %h exp %h", i, k, got, exp);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_extremes;
        do_reset(7'd1);
        for (int n = 0; n < 200; n++) begin
            i_data = 24'(n + 1);
            i_ctrl = 3'(n);
            tick();
            exp = {1'b1, 3'(n), 24'(n + 1)};
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL depth1 n=%0d got %h exp %h", n, got, exp);
            end
        end
        do_reset(7'd64);
        for (int n = 0; n < 200; n++) begin
            i_data = 24'(n);
            i_ctrl = 3'(n);
            tick();
            exp = (n >= 63) ? {1'b1, 3'(n - 63), 24'(n - 63)} : '0;
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL depth64 n=%0d got %h exp %h", n, got, exp);
            end
        end
    endtask

    task automatic test_runtime_change;
        do_reset(7'd8);
        for (int n = 0; n < 20; n++) begin
            i_data = 24'(n + 1);
            tick();
            exp = (n >= 7) ? {1'b1, 3'b0, 24'(n - 6)} : '0;
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL d8_stream n=%0d got %h exp %h", n, got, exp);
            end
        end
        delay_sel = 7'd3;
        i_data = 24'hFFFFFF;
        tick();
        got = {o_valid, o_ctrl, o_data};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL change_edge got %h exp %h", got, 28'h0);
        end
        for (int m = 1; m <= 10; m++) begin
            i_data = 24'(1000 + m);
            tick();
            exp = (m >= 3) ? {1'b1, 3'b0, 24'(1000 + m - 2)} : '0;
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL d3_after m=%0d got %h exp %h", m, got, exp);
            end
        end
        en = 1'b0;
        delay_sel = 7'd5;
        i_data = 24'h123456;
        tick();
        got = {o_valid, o_ctrl, o_data};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL change_en0 got %h exp %h", got, 28'h0);
        end
        en = 1'b1;
        for (int m = 1; m <= 10; m++) begin
            i_data = 24'(3000 + m);
            tick();
            exp = (m >= 5) ? {1'b1, 3'b0, 24'(3000 + m - 4)} : '0;
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL d5_after m=%0d got %h exp %h", m, got, exp);
            end
        end
    endtask

    task automatic test_range;
        do_reset(7'd0);
        for (int n = 0; n < 10; n++) begin
            i_data = 24'(n + 1);
            tick();
            exp_e = {1'b1, 1'b1, 3'b0, 24'(n + 1)};
            got_e = {cfg_err, o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got_e !== exp_e) begin
                n_bad++;
                $display("FAIL sel0 n=%0d got %h exp %h", n, got_e, exp_e);
            end
        end
        delay_sel = 7'd100;
        i_data = 24'hEEEEEE;
        tick();
        got_e = {cfg_err, o_valid, o_ctrl, o_data};
        n_cmp++;
        if (got_e !== {1'b1, 28'h0}) begin
            n_bad++;
            $display("FAIL sel100_change got %h exp %h", got_e, {1'b1, 28'h0});
        end
        for (int m = 1; m <= 70; m++) begin
            i_data = 24'(500 + m);
            tick();
            exp_e = (m >= 64) ? {1'b1, 1'b1, 3'b0, 24'(500 + m - 63)} : {1'b1, 28'h0};
            got_e = {cfg_err, o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got_e !== exp_e) begin
                n_bad++;
                $display("FAIL sel100 m=%0d got %h exp %h", m, got_e, exp_e);
            end
        end
        delay_sel = 7'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (cfg_err !== 1'b1) begin
                n_bad++;
                $display("FAIL cfg_sticky i=%0d got %b exp 1", i, cfg_err);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_clear got %b exp 0", cfg_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_reset(7'd10);
        for (int n = 0; n < 30; n++) begin
            i_data = 24'(n + 1);
            tick();
            exp = (n >= 9) ? {1'b1, 3'b0, 24'(n - 8)} : '0;
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL d10_stream n=%0d got %h exp %h", n, got, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {o_valid, o_ctrl, o_data};
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL async_clear got %h exp %h", got, 28'h0);
        end
        #1;
        rst_n = 1'b1;
        for (int m = 1; m <= 15; m++) begin
            i_data = 24'(2000 + m);
            tick();
            exp = (m >= 10) ? {1'b1, 3'b0, 24'(2000 + m - 9)} : '0;
            got = {o_valid, o_ctrl, o_data};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL after_reset m=%0d got %h exp %h", m, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_enable_gaps();
        test_extremes();
        test_runtime_change();
        test_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
